// File: rtl/black_noise_stats.sv
// black_noise_stats: per-frame noise statistics over a black-row window.
// Accumulates sum and sum-of-squares of 2**SAMPLES_LOG2 pixels per column-interleaved
// channel. When every channel is full, the totals are snapshotted and a two-stage pipeline
// emits one channel per cycle: truncated mean and truncated variance.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   pix_valid_i/pix_data_i pixel qualifier and unsigned pixel value
//   hd_i / vd_i            line / frame sync, rising edge = new row / new frame
//   res_valid_o            one-cycle pulse per channel result
//   res_ch_o               channel of the current result
//   res_mean_o, res_var_o  floor(sum/N), floor((N*sumsq - sum^2)/N^2); held between pulses
//   short_o                pulse: frame ended before all channels were filled
module black_noise_stats #(
    parameter int unsigned PIX_DATA_W   = 12,
    parameter int unsigned CH_NUM       = 2,
    parameter int unsigned SAMPLES_LOG2 = 10,
    parameter int unsigned ROW_START    = 1,
    parameter int unsigned ROW_NUM      = 10,
    localparam int unsigned CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    pix_valid_i,
    input  logic [PIX_DATA_W-1:0]   pix_data_i,
    input  logic                    hd_i,
    input  logic                    vd_i,
    output logic                    res_valid_o,
    output logic [CH_W-1:0]         res_ch_o,
    output logic [PIX_DATA_W-1:0]   res_mean_o,
    output logic [2*PIX_DATA_W-1:0] res_var_o,
    output logic                    short_o
);
    localparam int unsigned SUM_W  = PIX_DATA_W + SAMPLES_LOG2;
    localparam int unsigned SQ_W   = 2 * PIX_DATA_W + SAMPLES_LOG2;
    localparam int unsigned VAR_W  = 2 * PIX_DATA_W;
    localparam int unsigned DIFF_W = 2 * SUM_W;
    localparam int unsigned CNT_W  = SAMPLES_LOG2 + 1;
    localparam int unsigned ROW_W  = $clog2(ROW_START + ROW_NUM + 1);

    localparam logic [CNT_W-1:0]  NSamp    = CNT_W'(1) << SAMPLES_LOG2;
    localparam logic [ROW_W-1:0]  RowFirst = ROW_W'(ROW_START);
    localparam logic [ROW_W-1:0]  RowLast  = ROW_W'(ROW_START + ROW_NUM - 1);
    localparam logic [2:0]        CalcLast = 3'(CH_NUM);
    localparam logic [DIFF_W-1:0] VarMax   = DIFF_W'({VAR_W{1'b1}});

    typedef enum logic [1:0] {StIdle, StAccum, StCalc} state_e;

    state_e state_q, state_d;
    logic hd_q, vd_q, hd_edge, vd_edge;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;      // column counter kept modulo CH_NUM
    logic [SUM_W-1:0] sum_q [CH_NUM], sum_d [CH_NUM], snap_sum_q [CH_NUM], snap_sum_d [CH_NUM];
    logic [SQ_W-1:0]  sq_q [CH_NUM], sq_d [CH_NUM], snap_sq_q [CH_NUM], snap_sq_d [CH_NUM];
    logic [CNT_W-1:0] cnt_q [CH_NUM], cnt_d [CH_NUM];
    logic pend_q, pend_d, short_q, short_d;
    logic [2:0] calc_cnt_q, calc_cnt_d;
    logic in_win, accept, full_nxt, clr, issue;
    logic [CH_W-1:0]  issue_ch;
    logic [VAR_W-1:0] pix_ext, pix_sq;
    logic [DIFF_W-1:0] sum_ext;

    // Pipeline stage 1 and output registers.
    logic                  s1_vld_q;
    logic [CH_W-1:0]       s1_ch_q;
    logic [SUM_W-1:0]      s1_sum_q;
    logic [SQ_W-1:0]       s1_sq_q;
    logic [DIFF_W-1:0]     s1_sumsq_q, diff, var_full;
    logic                  res_valid_q;
    logic [CH_W-1:0]       res_ch_q;
    logic [PIX_DATA_W-1:0] res_mean_q;
    logic [VAR_W-1:0]      res_var_q;

    assign hd_edge = hd_i & ~hd_q;
    assign vd_edge = vd_i & ~vd_q;
    assign in_win  = (row_q >= RowFirst) && (row_q <= RowLast);
    assign accept  = pix_valid_i && in_win && (state_q == StAccum) && (cnt_q[ch_q] < NSamp);
    assign pix_ext = VAR_W'(pix_data_i);
    assign pix_sq  = pix_ext * pix_ext;

    always_comb begin
        row_d = row_q;
        if (vd_edge) begin
            row_d = '0;               // vd wins over a coincident hd
        end else if (hd_edge && (row_q != '1)) begin
            row_d = row_q + 1'b1;
        end
        ch_d = ch_q;
        if (hd_edge) begin
            ch_d = '0;
        end else if (pix_valid_i) begin
            ch_d = (ch_q == CH_W'(CH_NUM - 1)) ? '0 : ch_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        short_d    = 1'b0;
        calc_cnt_d = calc_cnt_q;
        snap_sum_d = snap_sum_q;
        snap_sq_d  = snap_sq_q;
        sum_d      = sum_q;
        sq_d       = sq_q;
        cnt_d      = cnt_q;
        clr        = 1'b0;
        full_nxt   = 1'b1;
        if (accept) begin
            sum_d[ch_q] = sum_q[ch_q] + SUM_W'(pix_data_i);
            sq_d[ch_q]  = sq_q[ch_q] + SQ_W'(pix_sq);
            cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
        end
        for (int c = 0; c < CH_NUM; c++) begin
            if (cnt_d[c] != NSamp) full_nxt = 1'b0;
        end
        unique case (state_q)
            StIdle: begin
                if (vd_edge) begin
                    state_d = StAccum;
                    clr     = 1'b1;
                end
            end
            StAccum: begin
                // A final accept coinciding with vd still completes the frame; vd is remembered.
                if (full_nxt) begin
                    snap_sum_d = sum_d;
                    snap_sq_d  = sq_d;
                    clr        = 1'b1;
                    state_d    = StCalc;
                    calc_cnt_d = '0;
                    pend_d     = vd_edge;
                end else if (vd_edge) begin
                    short_d = 1'b1;
                    clr     = 1'b1;
                end
            end
            StCalc: begin
                calc_cnt_d = calc_cnt_q + 1'b1;
                if (vd_edge) pend_d = 1'b1;
                // Stay until the last result has been registered.
                if (calc_cnt_q == CalcLast) begin
                    state_d = (pend_q || vd_edge) ? StAccum : StIdle;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clr) begin
            for (int c = 0; c < CH_NUM; c++) begin
                sum_d[c] = '0;
                sq_d[c]  = '0;
                cnt_d[c] = '0;
            end
        end
    end

    assign issue    = (state_q == StCalc) && (calc_cnt_q < CalcLast);
    assign issue_ch = calc_cnt_q[CH_W-1:0];
    assign sum_ext  = DIFF_W'(snap_sum_q[issue_ch]);
    // N*sumsq >= sum^2 always, so the subtraction cannot wrap.
    assign diff     = (DIFF_W'(s1_sq_q) << SAMPLES_LOG2) - s1_sumsq_q;
    assign var_full = diff >> (2 * SAMPLES_LOG2);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            hd_q        <= 1'b0;
            vd_q        <= 1'b0;
            row_q       <= '0;
            ch_q        <= '0;
            sum_q       <= '{default: '0};
            sq_q        <= '{default: '0};
            cnt_q       <= '{default: '0};
            snap_sum_q  <= '{default: '0};
            snap_sq_q   <= '{default: '0};
            pend_q      <= 1'b0;
            short_q     <= 1'b0;
            calc_cnt_q  <= '0;
            s1_vld_q    <= 1'b0;
            s1_ch_q     <= '0;
            s1_sum_q    <= '0;
            s1_sq_q     <= '0;
            s1_sumsq_q  <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_mean_q  <= '0;
            res_var_q   <= '0;
        end else begin
            state_q     <= state_d;
            hd_q        <= hd_i;
            vd_q        <= vd_i;
            row_q       <= row_d;
            ch_q        <= ch_d;
            sum_q       <= sum_d;
            sq_q        <= sq_d;
            cnt_q       <= cnt_d;
            snap_sum_q  <= snap_sum_d;
            snap_sq_q   <= snap_sq_d;
            pend_q      <= pend_d;
            short_q     <= short_d;
            calc_cnt_q  <= calc_cnt_d;
            s1_vld_q    <= issue;
            if (issue) begin
                s1_ch_q    <= issue_ch;
                s1_sum_q   <= snap_sum_q[issue_ch];
                s1_sq_q    <= snap_sq_q[issue_ch];
                s1_sumsq_q <= sum_ext * sum_ext;
            end
            res_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                res_ch_q   <= s1_ch_q;
                res_mean_q <= PIX_DATA_W'(s1_sum_q >> SAMPLES_LOG2);
                res_var_q  <= (var_full > VarMax) ? '1 : VAR_W'(var_full);
            end
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_ch_o    = res_ch_q;
    assign res_mean_o  = res_mean_q;
    assign res_var_o   = res_var_q;
    assign short_o     = short_q;

endmodule

// File: tb/tb_black_noise_stats.sv
// tb_black_noise_stats: directed bench for black_noise_stats with CH_NUM=2, SAMPLES_LOG2=4,
// ROW_START=1, ROW_NUM=2. Each window row carries 16 pixels (8 per channel), so two window
// rows fill both channels exactly.
module tb_black_noise_stats;
    logic        clk = 1'b0;
    logic        rst_i, pix_valid_i, hd_i, vd_i;
    logic [11:0] pix_data_i;
    logic        res_valid_o, short_o;
    logic [0:0]  res_ch_o;
    logic [11:0] res_mean_o;
    logic [23:0] res_var_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_t = 0;
    int short_cnt = 0;

    typedef struct {int ch; int mean; int vr; int t;} res_t;
    res_t res_q[$];

    black_noise_stats #(
        .PIX_DATA_W  (12),
        .CH_NUM      (2),
        .SAMPLES_LOG2(4),
        .ROW_START   (1),
        .ROW_NUM     (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .pix_valid_i(pix_valid_i),
        .pix_data_i (pix_data_i),
        .hd_i       (hd_i),
        .vd_i       (vd_i),
        .res_valid_o(res_valid_o),
        .res_ch_o   (res_ch_o),
        .res_mean_o (res_mean_o),
        .res_var_o  (res_var_o),
        .short_o    (short_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        res_t r;
        if (!rst_i) begin
            if (res_valid_o) begin
                r.ch = int'(res_ch_o);
                r.mean = int'(res_mean_o);
                r.vr = int'(res_var_o);
                r.t = cyc;
                res_q.push_back(r);
            end
            if (short_o) short_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pv(input int mode, input int ch, input int k);
        case (mode)
            0: return 100;
            1: return (ch == 0) ? ((k % 2 != 0) ? 102 : 98) : k;
            2: return (ch == 0) ? 50 : 200;
            default: return (ch == 0) ? ((k % 2 != 0) ? 4095 : 0) : 4095;
        endcase
    endfunction

    task automatic drive_px(input int v);
        pix_valid_i = 1'b1;
        pix_data_i = 12'(v);
        tick();
    endtask

    task automatic hd_pulse();
        pix_valid_i = 1'b0;
        hd_i = 1'b1;
        tick();
        hd_i = 1'b0;
        tick();
        tick();
    endtask

    // endvd: 0 normal ending, 1 vd rises with the last window pixel, 2 vd rises the cycle
    // after, 3 stop right after the last window pixel (no vd, no trailing rows).
    task automatic send_frame(input int mode, input int row2_w, input int endvd, input bit do_vd);
        if (do_vd) begin
            pix_valid_i = 1'b0;
            vd_i = 1'b1;
            tick();
            tick();
            vd_i = 1'b0;
            tick();
        end
        for (int c = 0; c < 4; c++) drive_px(4095);
        hd_pulse();
        for (int c = 0; c < 16; c++) drive_px(pv(mode, c % 2, c / 2));
        hd_pulse();
        for (int c = 0; c < row2_w; c++) begin
            if (c == 15) last_t = cyc;
            if (c == 15 && endvd == 1) vd_i = 1'b1;
            drive_px((c < 16) ? pv(mode, c % 2, 8 + c / 2) : 4095);
            if (c == 15 && endvd != 0) begin
                pix_valid_i = 1'b0;
                if (endvd != 3) begin
                    vd_i = 1'b1;
                    tick();
                    tick();
                    vd_i = 1'b0;
                    tick();
                end
                return;
            end
        end
        hd_pulse();
        for (int c = 0; c < 4; c++) drive_px(4095);
        pix_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        pix_valid_i = 1'b0;
        pix_data_i = '0;
        hd_i = 1'b0;
        vd_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({res_valid_o, res_ch_o, res_mean_o, res_var_o, short_o} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got valid=%0b ch=%0d mean=%0d var=%0d short=%0b, want all 0",
                     res_valid_o, res_ch_o, res_mean_o, res_var_o, short_o);
        end
        rst_i = 1'b0;
        repeat (3) tick();
        checks++;
        if ({res_valid_o, res_mean_o, res_var_o, short_o} !== '0) begin
            failures++;
            $display("FAIL reset_release: got valid=%0b mean=%0d var=%0d short=%0b, want all 0",
                     res_valid_o, res_mean_o, res_var_o, short_o);
        end
    endtask

    task automatic test_frames();
        int em0[4] = '{100, 100, 50, 2047};
        int ev0[4] = '{0, 4, 0, 4192256};
        int em1[4] = '{100, 7, 200, 4095};
        int ev1[4] = '{0, 21, 0, 0};
        int wm, wv;
        for (int m = 0; m < 4; m++) begin
            res_q.delete();
            send_frame(m, (m == 2) ? 20 : 16, 0, 1'b1);
            repeat (6) tick();
            checks++;
            if (res_q.size() != 2) begin
                failures++;
                $display("FAIL frame%0d_count: got %0d results, want 2", m, res_q.size());
            end
            for (int i = 0; i < 2; i++) begin
                if (i < res_q.size()) begin
                    wm = (i == 0) ? em0[m] : em1[m];
                    wv = (i == 0) ? ev0[m] : ev1[m];
                    checks++;
                    if (res_q[i].ch !== i || res_q[i].mean !== wm || res_q[i].vr !== wv ||
                        res_q[i].t !== last_t + 3 + i) begin
                        failures++;
                        $display("FAIL frame%0d_res%0d: got ch=%0d mean=%0d var=%0d t=%0d, want ch=%0d mean=%0d var=%0d t=%0d",
                                 m, i, res_q[i].ch, res_q[i].mean, res_q[i].vr, res_q[i].t,
                                 i, wm, wv, last_t + 3 + i);
                    end
                end
            end
        end
    endtask

    task automatic test_short();
        int wm[2] = '{100, 7};
        int wv[2] = '{4, 21};
        res_q.delete();
        short_cnt = 0;
        send_frame(0, 4, 0, 1'b1);
        repeat (6) tick();
        checks++;
        if (res_q.size() != 0 || short_cnt != 0) begin
            failures++;
            $display("FAIL short_partial: got results=%0d short=%0d, want 0 and 0",
                     res_q.size(), short_cnt);
        end
        send_frame(1, 16, 0, 1'b1);
        repeat (6) tick();
        checks++;
        if (short_cnt != 1 || res_q.size() != 2) begin
            failures++;
            $display("FAIL short_pulse: got short cycles=%0d results=%0d, want 1 and 2",
                     short_cnt, res_q.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (i < res_q.size()) begin
                checks++;
                if (res_q[i].ch !== i || res_q[i].mean !== wm[i] || res_q[i].vr !== wv[i] ||
                    res_q[i].t !== last_t + 3 + i) begin
                    failures++;
                    $display("FAIL short_next%0d: got ch=%0d mean=%0d var=%0d t=%0d, want ch=%0d mean=%0d var=%0d t=%0d",
                             i, res_q[i].ch, res_q[i].mean, res_q[i].vr, res_q[i].t,
                             i, wm[i], wv[i], last_t + 3 + i);
                end
            end
        end
    endtask

    // Two frames with no IDLE gap: the second frame's vd edge lands either on the final
    // accept (endvd=1) or inside CALC (endvd=2); the second frame has no vd of its own.
    task automatic test_back_to_back(input int endvd, input int ma, input int mb);
        int em[4];
        int ev[4];
        int et[4];
        int ta;
        int em0[4] = '{100, 100, 50, 2047};
        int ev0[4] = '{0, 4, 0, 4192256};
        int em1[4] = '{100, 7, 200, 4095};
        int ev1[4] = '{0, 21, 0, 0};
        res_q.delete();
        short_cnt = 0;
        send_frame(ma, 16, endvd, 1'b1);
        ta = last_t;
        send_frame(mb, 20, 0, 1'b0);
        repeat (6) tick();
        em = '{em0[ma], em1[ma], em0[mb], em1[mb]};
        ev = '{ev0[ma], ev1[ma], ev0[mb], ev1[mb]};
        et = '{ta + 3, ta + 4, last_t + 3, last_t + 4};
        checks++;
        if (res_q.size() != 4 || short_cnt != 0) begin
            failures++;
            $display("FAIL b2b%0d_count: got results=%0d short=%0d, want 4 and 0",
                     endvd, res_q.size(), short_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < res_q.size()) begin
                checks++;
                if (res_q[i].ch !== i % 2 || res_q[i].mean !== em[i] || res_q[i].vr !== ev[i] ||
                    res_q[i].t !== et[i]) begin
                    failures++;
                    $display("FAIL b2b%0d_res%0d: got ch=%0d mean=%0d var=%0d t=%0d, want ch=%0d mean=%0d var=%0d t=%0d",
                             endvd, i, res_q[i].ch, res_q[i].mean, res_q[i].vr, res_q[i].t,
                             i % 2, em[i], ev[i], et[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        res_q.delete();
        short_cnt = 0;
        // Mid-ACCUM: 10 samples per channel collected, then reset.
        send_frame(0, 4, 0, 1'b1);
        rst_i = 1'b1;
        #1;
        checks++;
        if ({res_valid_o, res_ch_o, res_mean_o, res_var_o, short_o} !== '0) begin
            failures++;
            $display("FAIL rst_accum: got valid=%0b ch=%0d mean=%0d var=%0d short=%0b, want all 0",
                     res_valid_o, res_ch_o, res_mean_o, res_var_o, short_o);
        end
        tick();
        rst_i = 1'b0;
        tick();
        // No vd edge yet, so a full set of rows must be ignored.
        send_frame(0, 16, 0, 1'b0);
        repeat (6) tick();
        checks++;
        if (res_q.size() != 0 || short_cnt != 0) begin
            failures++;
            $display("FAIL rst_wait_vd: got results=%0d short=%0d, want 0 and 0",
                     res_q.size(), short_cnt);
        end
        // Mid-CALC: reset one cycle after the snapshot, before any result appears.
        send_frame(2, 16, 3, 1'b1);
        tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if ({res_valid_o, res_ch_o, res_mean_o, res_var_o, short_o} !== '0) begin
            failures++;
            $display("FAIL rst_calc: got valid=%0b ch=%0d mean=%0d var=%0d short=%0b, want all 0",
                     res_valid_o, res_ch_o, res_mean_o, res_var_o, short_o);
        end
        tick();
        rst_i = 1'b0;
        repeat (8) tick();
        checks++;
        if (res_q.size() != 0 || short_cnt != 0) begin
            failures++;
            $display("FAIL rst_calc_quiet: got results=%0d short=%0d, want 0 and 0",
                     res_q.size(), short_cnt);
        end
        send_frame(3, 16, 0, 1'b1);
        repeat (6) tick();
        checks++;
        if (res_q.size() != 2 || short_cnt != 0) begin
            failures++;
            $display("FAIL rst_recover_count: got results=%0d short=%0d, want 2 and 0",
                     res_q.size(), short_cnt);
        end else begin
            checks++;
            if (res_q[0].mean !== 2047 || res_q[0].vr !== 4192256 || res_q[1].mean !== 4095 ||
                res_q[1].vr !== 0 || res_q[0].t !== last_t + 3 || res_q[1].t !== last_t + 4) begin
                failures++;
                $display("FAIL rst_recover: got m0=%0d v0=%0d t0=%0d m1=%0d v1=%0d t1=%0d, want 2047 4192256 %0d 4095 0 %0d",
                         res_q[0].mean, res_q[0].vr, res_q[0].t, res_q[1].mean, res_q[1].vr,
                         res_q[1].t, last_t + 3, last_t + 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_short();
        test_back_to_back(1, 0, 2);
        test_back_to_back(2, 1, 3);
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
